// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART transmitter: FSM states, parity modes
// and the elaboration-time baud divisor.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PAR,
    ST_STOP
  } state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  // Rounded to nearest so the bit period error stays below half a clock.
  function automatic int calc_div(input longint clk_freq, input longint baud);
    return int'((clk_freq + baud / 2) / baud);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered read data: pop_data is valid the cycle after pop.
// Pushes while full and pops while empty are ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_chk_depth
    $error("sync_fifo: DEPTH must be a power of two and at least 2");
  end

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic [WIDTH-1:0] r_rdata;
  logic             w_push;
  logic             w_pop;

  assign full     = (r_count == FULL_CNT);
  assign empty    = (r_count == '0);
  assign count    = r_count;
  assign pop_data = r_rdata;
  assign w_push   = push & ~full;
  assign w_pop    = pop & ~empty;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_rdata <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop) begin
        r_rptr  <= r_rptr + 1'b1;
        r_rdata <= r_mem[r_rptr];
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: FIFO-fed serialiser with configurable frame format.
// state | meaning
// IDLE  | line high, waiting for queued data
// START | start bit low; first cycle latches the popped word into the shift register
// DATA  | payload bits, LSB first
// PAR   | optional parity bit
// STOP  | stop bit(s) high; pops the next word so frames follow without a gap
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DATA_BITS-1:0]          tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          uart_txd,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  input  logic                          clr_ovf
);
  localparam int DIV = calc_div(CLK_FREQ, BAUD);
  localparam int CW  = $clog2(DIV);

  if (DIV < 2) begin : g_chk_div
    $error("uart_tx_fifo: baud divisor below 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_chk_bits
    $error("uart_tx_fifo: DATA_BITS must be 5..9");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_chk_stop
    $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
  end

  state_t               r_state;
  logic [CW-1:0]        r_baud;
  logic [3:0]           r_bit;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par;
  logic                 r_load;
  logic                 r_txd;
  logic                 r_ovf;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_pop;
  logic                 w_baud_end;
  logic                 w_last_stop;
  logic [DATA_BITS-1:0] w_head;

  assign w_baud_end  = (r_baud == CW'(DIV - 1));
  assign w_last_stop = (r_state == ST_STOP) && w_baud_end && (r_bit == 4'(STOP_BITS - 1));
  assign w_pop       = ~w_empty && ((r_state == ST_IDLE) || w_last_stop);

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (tx_valid),
    .push_data (tx_data),
    .pop       (w_pop),
    .pop_data  (w_head),
    .full      (w_full),
    .empty     (w_empty),
    .count     (fifo_count)
  );

  // The line output lags the state by one cycle, so every bit still lasts DIV cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_load  <= 1'b0;
      r_txd   <= 1'b1;
    end else begin
      r_load <= w_pop;
      case (r_state)
        ST_IDLE: begin
          r_txd  <= 1'b1;
          r_baud <= '0;
          r_bit  <= '0;
          if (w_pop) r_state <= ST_START;
        end
        ST_START: begin
          r_txd <= 1'b0;
          if (r_load) begin
            r_shift <= w_head;
            r_par   <= (PARITY == PARITY_ODD) ? ~^w_head : ^w_head;
          end
          if (w_baud_end) begin
            r_baud  <= '0;
            r_state <= ST_DATA;
          end else r_baud <= r_baud + 1'b1;
        end
        ST_DATA: begin
          r_txd <= r_shift[0];
          if (w_baud_end) begin
            r_baud  <= '0;
            r_shift <= r_shift >> 1;
            if (r_bit == 4'(DATA_BITS - 1)) begin
              r_bit   <= '0;
              r_state <= (PARITY != PARITY_NONE) ? ST_PAR : ST_STOP;
            end else r_bit <= r_bit + 1'b1;
          end else r_baud <= r_baud + 1'b1;
        end
        ST_PAR: begin
          r_txd <= r_par;
          if (w_baud_end) begin
            r_baud  <= '0;
            r_state <= ST_STOP;
          end else r_baud <= r_baud + 1'b1;
        end
        ST_STOP: begin
          r_txd <= 1'b1;
          if (w_baud_end) begin
            r_baud <= '0;
            if (r_bit == 4'(STOP_BITS - 1)) begin
              r_bit   <= '0;
              r_state <= w_pop ? ST_START : ST_IDLE;
            end else r_bit <= r_bit + 1'b1;
          end else r_baud <= r_baud + 1'b1;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_ovf <= 1'b0;
    else if (tx_valid && w_full) r_ovf <= 1'b1;
    else if (clr_ovf) r_ovf <= 1'b0;
  end

  assign uart_txd = r_txd;
  assign tx_ready = ~w_full;
  assign overflow = r_ovf;
  assign busy     = (r_state != ST_IDLE) || (fifo_count != '0);

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: five parameter variants, frames checked cycle by cycle
// against frames rebuilt from the queued bytes.
module tb_uart_tx_fifo;
  localparam int DIV_DEF  = 434;
  localparam int DIV_7    = 5208;
  localparam int DIV_FAST = 4;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] din [5];
  logic       vld [5];
  logic       clr [5];
  logic       rdy [5];
  logic       txd [5];
  logic       bsy [5];
  logic       ovf [5];
  logic [4:0] cnt [5];
  int         passed = 0;
  int         total  = 0;
  logic [7:0] sb [$];

  always #5 clk = ~clk;

  uart_tx_fifo u_def (.clk(clk), .rst_n(rst_n), .tx_data(din[0]), .tx_valid(vld[0]),
    .tx_ready(rdy[0]), .uart_txd(txd[0]), .busy(bsy[0]), .fifo_count(cnt[0]),
    .overflow(ovf[0]), .clr_ovf(clr[0]));
  uart_tx_fifo #(.PARITY(2), .STOP_BITS(2)) u_even (.clk(clk), .rst_n(rst_n),
    .tx_data(din[1]), .tx_valid(vld[1]), .tx_ready(rdy[1]), .uart_txd(txd[1]),
    .busy(bsy[1]), .fifo_count(cnt[1]), .overflow(ovf[1]), .clr_ovf(clr[1]));
  uart_tx_fifo #(.PARITY(1), .STOP_BITS(2)) u_odd (.clk(clk), .rst_n(rst_n),
    .tx_data(din[2]), .tx_valid(vld[2]), .tx_ready(rdy[2]), .uart_txd(txd[2]),
    .busy(bsy[2]), .fifo_count(cnt[2]), .overflow(ovf[2]), .clr_ovf(clr[2]));
  uart_tx_fifo #(.CLK_FREQ(1_000_000), .BAUD(250_000)) u_fast (.clk(clk), .rst_n(rst_n),
    .tx_data(din[3]), .tx_valid(vld[3]), .tx_ready(rdy[3]), .uart_txd(txd[3]),
    .busy(bsy[3]), .fifo_count(cnt[3]), .overflow(ovf[3]), .clr_ovf(clr[3]));
  uart_tx_fifo #(.DATA_BITS(7), .BAUD(9600)) u_d7 (.clk(clk), .rst_n(rst_n),
    .tx_data(din[4][6:0]), .tx_valid(vld[4]), .tx_ready(rdy[4]), .uart_txd(txd[4]),
    .busy(bsy[4]), .fifo_count(cnt[4]), .overflow(ovf[4]), .clr_ovf(clr[4]));

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic get_txd(input int id);
    return txd[id];
  endfunction

  // Line levels of one frame: start, payload LSB first, optional parity, stop bits.
  function automatic int build_frame(input logic [7:0] data, input int nb, input int par,
                                     input int stops, output logic [15:0] bits);
    int n;
    int ones;
    n    = 0;
    ones = 0;
    bits = '1;
    bits[n] = 1'b0;
    n++;
    for (int i = 0; i < nb; i++) begin
      bits[n] = data[i];
      ones += int'(data[i]);
      n++;
    end
    if (par != 0) begin
      bits[n] = (((ones + ((par == 1) ? 1 : 0)) % 2) != 0);
      n++;
    end
    for (int i = 0; i < stops; i++) begin
      bits[n] = 1'b1;
      n++;
    end
    return n;
  endfunction

  task automatic push(input int id, input logic [7:0] d);
    din[id] = d;
    vld[id] = 1'b1;
    tick();
    vld[id] = 1'b0;
  endtask

  task automatic wait_fall(input int id, input int budget, input string name, output int waited);
    waited = 0;
    while (get_txd(id) !== 1'b0 && waited < budget) begin
      tick();
      waited++;
    end
    if (get_txd(id) !== 1'b0) begin
      total++;
      $display("FAIL %s: no start bit within %0d cycles", name, budget);
    end
  endtask

  // Starts on the first cycle of the start bit; ends on the first cycle after the frame.
  task automatic check_frame(input int id, input int div, input logic [15:0] bits,
                             input int n, input string name);
    logic bad;
    logic got;
    int   at;
    for (int b = 0; b < n; b++) begin
      bad = 1'b0;
      got = 1'b0;
      at  = 0;
      for (int c = 0; c < div; c++) begin
        if (!bad && get_txd(id) !== bits[b]) begin
          bad = 1'b1;
          got = get_txd(id);
          at  = c;
        end
        tick();
      end
      total++;
      if (bad) $display("FAIL %s bit%0d cycle%0d: uart_txd=%b expected %b", name, b, at, got, bits[b]);
      else passed++;
    end
  endtask

  task automatic check_idle(input int id, input string name);
    total++;
    if (txd[id] !== 1'b1 || bsy[id] !== 1'b0 || cnt[id] !== 5'd0)
      $display("FAIL %s idle: txd=%b busy=%b count=%0d expected 1 0 0", name, txd[id], bsy[id], cnt[id]);
    else passed++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(3);
    for (int i = 0; i < 5; i++) begin
      total++;
      if ({txd[i], rdy[i], bsy[i], ovf[i]} !== 4'b1100)
        $display("FAIL reset_flags[%0d]: txd,ready,busy,ovf=%b expected 1100", i,
                 {txd[i], rdy[i], bsy[i], ovf[i]});
      else passed++;
      total++;
      if (cnt[i] !== 5'd0) $display("FAIL reset_count[%0d]: %0d expected 0", i, cnt[i]);
      else passed++;
    end
    rst_n = 1'b1;
    tick(2);
  endtask

  task automatic test_8n1();
    logic [15:0] bits;
    int n;
    int w;
    n = build_frame(8'h35, 8, 0, 1, bits);
    push(0, 8'h35);
    total++;
    if (cnt[0] !== 5'd1) $display("FAIL 8n1_count_after_push: %0d expected 1", cnt[0]);
    else passed++;
    wait_fall(0, 10, "8n1", w);
    total++;
    if (w !== 2) $display("FAIL 8n1_latency: %0d cycles expected 2", w);
    else passed++;
    total++;
    if (bsy[0] !== 1'b1) $display("FAIL 8n1_busy_in_frame: %b expected 1", bsy[0]);
    else passed++;
    check_frame(0, DIV_DEF, bits, n, "8n1_0x35");
    check_idle(0, "8n1_after_stop");
  endtask

  task automatic test_parity();
    logic [7:0] second;
    second = 8'($urandom_range(0, 255));
    din[1] = 8'h35; din[2] = 8'h35;
    vld[1] = 1'b1;  vld[2] = 1'b1;
    tick();
    din[1] = second; din[2] = second;
    tick();
    vld[1] = 1'b0;  vld[2] = 1'b0;
    fork
      for (int id = 1; id <= 2; id++) begin
        automatic int me = id;
        fork
          begin
            logic [15:0] bits;
            int n;
            int w;
            wait_fall(me, 10, "parity", w);
            total++;
            if (w !== 1) $display("FAIL parity%0d_latency: %0d expected 1", me, w);
            else passed++;
            n = build_frame(8'h35, 8, (me == 1) ? 2 : 1, 2, bits);
            check_frame(me, DIV_DEF, bits, n, (me == 1) ? "even_0x35" : "odd_0x35");
            n = build_frame(second, 8, (me == 1) ? 2 : 1, 2, bits);
            check_frame(me, DIV_DEF, bits, n, (me == 1) ? "even_next" : "odd_next");
            check_idle(me, "parity_end");
          end
        join_none
      end
    join
    wait fork;
  endtask

  task automatic test_data7();
    logic [15:0] bits;
    int n;
    int w;
    n = build_frame(8'h41, 7, 0, 1, bits);
    push(4, 8'h41);
    wait_fall(4, 10, "d7", w);
    total++;
    if (w !== 2) $display("FAIL d7_latency: %0d expected 2", w);
    else passed++;
    check_frame(4, DIV_7, bits, n, "7n1_0x41");
    check_idle(4, "7n1_after_stop");
  endtask

  task automatic test_reset_midframe();
    int w;
    int bad;
    for (int k = 0; k < 3; k++) begin
      din[0] = 8'($urandom_range(0, 255));
      vld[0] = 1'b1;
      tick();
    end
    vld[0] = 1'b0;
    wait_fall(0, 10, "rst_mid", w);
    tick(1000);
    rst_n = 1'b0;
    #1;
    total++;
    if (txd[0] !== 1'b1 || cnt[0] !== 5'd0 || bsy[0] !== 1'b0)
      $display("FAIL rst_mid_async: txd=%b count=%0d busy=%b expected 1 0 0", txd[0], cnt[0], bsy[0]);
    else passed++;
    tick(2);
    rst_n = 1'b1;
    bad = 0;
    for (int c = 0; c < 5000; c++) begin
      tick();
      if (txd[0] !== 1'b1 || bsy[0] !== 1'b0) bad++;
    end
    total++;
    if (bad != 0) $display("FAIL rst_mid_quiet: %0d active cycles expected 0", bad);
    else passed++;
  endtask

  task automatic monitor_fast(input int frames, input string name);
    logic [15:0] bits;
    int n;
    int w;
    wait_fall(3, 10, name, w);
    for (int f = 0; f < frames; f++) begin
      if (sb.size() == 0) begin
        total++;
        $display("FAIL %s: frame %0d with no byte queued", name, f);
        break;
      end
      n = build_frame(sb.pop_front(), 8, 0, 1, bits);
      check_frame(3, DIV_FAST, bits, n, name);
    end
    check_idle(3, name);
  endtask

  task automatic test_burst();
    sb.delete();
    fork
      begin
        logic [7:0] d;
        for (int k = 0; k < 20; k++) begin
          d = 8'($urandom_range(0, 255));
          din[3] = d;
          vld[3] = 1'b1;
          total++;
          if (rdy[3] !== (k < 17)) $display("FAIL burst_ready push%0d: %b expected %b", k, rdy[3], (k < 17));
          else passed++;
          if (k < 17) sb.push_back(d);
          tick();
        end
        vld[3] = 1'b0;
        total++;
        if (cnt[3] !== 5'd16 || ovf[3] !== 1'b1 || rdy[3] !== 1'b0)
          $display("FAIL burst_full: count=%0d ovf=%b ready=%b expected 16 1 0", cnt[3], ovf[3], rdy[3]);
        else passed++;
        clr[3] = 1'b1;
        tick();
        clr[3] = 1'b0;
        total++;
        if (ovf[3] !== 1'b0) $display("FAIL burst_clr_ovf: %b expected 0", ovf[3]);
        else passed++;
        tick(20);
        din[3] = 8'($urandom_range(0, 255));
        vld[3] = 1'b1;
        clr[3] = 1'b1;
        tick();
        vld[3] = 1'b0;
        clr[3] = 1'b0;
        total++;
        if (cnt[3] !== 5'd15 || ovf[3] !== 1'b1)
          $display("FAIL full_push_on_pop: count=%0d ovf=%b expected 15 1", cnt[3], ovf[3]);
        else passed++;
      end
      monitor_fast(17, "burst");
    join
  endtask

  task automatic test_coincide();
    sb.delete();
    fork
      begin
        logic [7:0] d;
        for (int k = 0; k < 6; k++) begin
          d = 8'($urandom_range(0, 255));
          din[3] = d;
          vld[3] = 1'b1;
          sb.push_back(d);
          tick();
        end
        vld[3] = 1'b0;
        total++;
        if (cnt[3] !== 5'd5) $display("FAIL coincide_pre: count=%0d expected 5", cnt[3]);
        else passed++;
        tick(35);
        d = 8'($urandom_range(0, 255));
        din[3] = d;
        vld[3] = 1'b1;
        sb.push_back(d);
        tick();
        vld[3] = 1'b0;
        total++;
        if (cnt[3] !== 5'd5) $display("FAIL coincide_push_pop: count=%0d expected 5", cnt[3]);
        else passed++;
        tick();
        total++;
        if (cnt[3] !== 5'd5) $display("FAIL coincide_after: count=%0d expected 5", cnt[3]);
        else passed++;
      end
      monitor_fast(7, "coincide");
    join
  endtask

  initial begin
    for (int i = 0; i < 5; i++) begin
      din[i] = '0;
      vld[i] = 1'b0;
      clr[i] = 1'b0;
    end
    test_reset();
    test_8n1();
    test_parity();
    test_data7();
    test_reset_midframe();
    test_burst();
    test_coincide();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Parametrised, buffered UART transmitter. Successor to the fixed 8N1 result sender in the MNIST top level, which drives uart_txd.
- The classifier core and the key-triggered report logic push result bytes (digit, score, CR/LF) into a FIFO. The block serialises them back-to-back on uart_txd.
- Adds configurable baud rate, data width, parity and stop bits, plus a ready/valid push interface, fill count and sticky overflow flag.

Parameters:
- CLK_FREQ, 50_000_000: sys clock in Hz.
- BAUD, 115200: line rate in bit/s.
- DATA_BITS, 8: payload bits per frame, legal range 5..9.
- PARITY, 0: 0 none, 1 odd, 2 even.
- STOP_BITS, 1: legal values 1 or 2.
- FIFO_DEPTH, 16: entries; power of two, at least 2.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- tx_data  in  DATA_BITS  byte to queue.
- tx_valid  in  1  push request.
- tx_ready  out  1  FIFO not full; push accepted when tx_valid & tx_ready.
- uart_txd  out  1  serial line, idle high.
- busy  out  1  high while a frame is on the line or the FIFO is non-empty.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- overflow  out  1  sticky; set when tx_valid is high while tx_ready is low.
- clr_ovf  in  1  synchronous clear of overflow.

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset values: uart_txd=1, tx_ready=1, busy=0, fifo_count=0, overflow=0. FIFO pointers cleared, FSM in IDLE, baud counter 0.
- Baud divisor: DIV = (CLK_FREQ + BAUD/2) / BAUD, computed at elaboration. Every bit lasts exactly DIV clk cycles; the counter runs 0..DIV-1. Elaboration error if DIV < 2.
- FSM states: IDLE, START, DATA, PAR, STOP.
  - IDLE: uart_txd=1. If the FIFO is non-empty, pop the head into the shift register and go to START next cycle.
  - START: uart_txd=0 for DIV cycles, then DATA.
  - DATA: send DATA_BITS bits LSB first, DIV cycles each. Then go to PAR if PARITY!=0, else STOP.
  - PAR: send the parity bit. Odd mode: XNOR-reduce of the payload. Even mode: XOR-reduce.
  - STOP: uart_txd=1 for STOP_BITS*DIV cycles.
- End of frame:
  - If the FIFO is non-empty, pop and go directly to START. There is no extra idle gap; consecutive frames are exactly one frame period apart.
  - Otherwise go to IDLE.
- Latency: first push into an empty idle block has uart_txd fall 2 cycles after the accepting edge (1 cycle write, 1 cycle pop).
- FIFO rules:
  - Push and pop in the same cycle: count unchanged, both take effect.
  - Full: tx_ready=0. A push is refused even if a pop occurs that cycle.
  - Empty with simultaneous push: the new entry becomes visible to the FSM the next cycle.
  - Refused push: data is dropped and overflow is set.
  - If clr_ovf and a new overflow event occur in the same cycle, set wins.
- Reset mid-frame: uart_txd returns high asynchronously, FIFO contents are discarded, and no partial frame resumes.
- busy = (state != IDLE) | (fifo_count != 0).

Decomposition:
- Shared package uart_pkg holds:
  - state encoding enum;
  - PARITY_NONE/ODD/EVEN constants;
  - function calc_div(clk_freq, baud).
- Sub-module sync_fifo, parametrised WIDTH and DEPTH. It provides push/pop, full, empty and count, with first-word-not-fall-through reads.
- The FSM, baud counter, shift register and parity logic stay in uart_tx_fifo.

Test Plan:
- 8N1 default, push 0x35 -> DIV=434; uart_txd sequence 0,1,0,1,0,1,1,0,0,1, each bit 434 cycles, frame 4340 cycles; busy low 1 cycle after stop ends.
- PARITY=2, then PARITY=1, STOP_BITS=2, push 0x35 -> parity bit 0 (even), then 1 (odd); stop high 868 cycles; frame 5208 cycles.
- Burst of 20 pushes with FIFO_DEPTH=16 while the line is idle:
  - tx_ready drops after 17 accepted: 1 popped immediately, 16 queued.
  - Remaining pushes set overflow.
  - 17 frames are sent back-to-back with no gap.
  - clr_ovf clears overflow.
- Assert rst_n low 1000 cycles into a frame -> uart_txd=1 immediately, fifo_count=0; after release, no output until a new push.
- Push and pop coincide at fifo_count=5 -> count stays 5. Push at full during a pop -> refused, overflow=1.
- DATA_BITS=7, BAUD=9600 -> DIV=5208; 0x41 sent as 0,1,0,0,0,0,0,1,1 (start, 7 data bits, stop).
